// File: rtl/axil_cmd_master.sv
// axil_cmd_master: single-outstanding AXI-Lite initiator that turns a command/response
// stream into one AXI-Lite read or write transaction per command.
module axil_cmd_master #(
    parameter int          ADDR_WIDTH = 9,
    parameter int          DATA_WIDTH = 32,
    parameter int          STRB_WIDTH = DATA_WIDTH / 8,
    parameter logic [2:0]  PROT       = 3'b000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);
    typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, RSP} state_t;
    state_t state, state_d;
    logic   accept;

    assign accept        = (state == IDLE) && cmd_valid && cmd_ready;
    assign m_axil_awprot = PROT;
    assign m_axil_arprot = PROT;

    // WRITE exits once each channel has either handshaken earlier or does so now
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = cmd_write ? WRITE : READ;
            WRITE:   if ((!m_axil_awvalid || m_axil_awready) && (!m_axil_wvalid || m_axil_wready)) state_d = WRESP;
            WRESP:   if (m_axil_bvalid) state_d = RSP;
            READ:    if (m_axil_arready) state_d = RDATA;
            RDATA:   if (m_axil_rvalid) state_d = RSP;
            RSP:     if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            cmd_ready      <= 1'b0;
            m_axil_awvalid <= 1'b0;
            m_axil_wvalid  <= 1'b0;
            m_axil_arvalid <= 1'b0;
            m_axil_bready  <= 1'b0;
            m_axil_rready  <= 1'b0;
            rsp_valid      <= 1'b0;
            m_axil_awaddr  <= '0;
            m_axil_araddr  <= '0;
            m_axil_wdata   <= '0;
            m_axil_wstrb   <= '0;
            rsp_write      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_resp       <= '0;
        end else begin
            state          <= state_d;
            cmd_ready      <= state_d == IDLE;
            m_axil_awvalid <= (accept && cmd_write) || (m_axil_awvalid && !m_axil_awready);
            m_axil_wvalid  <= (accept && cmd_write) || (m_axil_wvalid && !m_axil_wready);
            m_axil_arvalid <= (accept && !cmd_write) || (m_axil_arvalid && !m_axil_arready);
            m_axil_bready  <= state_d == WRESP;
            m_axil_rready  <= state_d == RDATA;
            rsp_valid      <= state_d == RSP;
            if (accept) begin
                m_axil_awaddr <= cmd_addr;
                m_axil_araddr <= cmd_addr;
                m_axil_wdata  <= cmd_wdata;
                m_axil_wstrb  <= cmd_wstrb;
            end
            if (state == WRESP && m_axil_bvalid) begin
                rsp_write <= 1'b1;
                rsp_rdata <= '0;
                rsp_resp  <= m_axil_bresp;
            end
            if (state == RDATA && m_axil_rvalid) begin
                rsp_write <= 1'b0;
                rsp_rdata <= m_axil_rdata;
                rsp_resp  <= m_axil_rresp;
            end
        end
    end
endmodule
